register_loader: RTL and testbench

//  Write-side counterpart of the 4:1 source selector: decodes a 2-bit destination

---
 rtl/minicpu_pkg.sv | 14 +
 rtl/out_fifo.sv | 53 +++++
 rtl/register_loader.sv | 103 ++++++++++
 tb/tb_register_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/minicpu_pkg.sv
// Shared types for the mini CPU datapath.
// Destination select encoding and default data width.
package minicpu_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    LD_A   = 2'b00,
    LD_B   = 2'b01,
    LD_OUT = 2'b10,
    LD_PC  = 2'b11
  } ld_sel_e;

endpackage

// File: rtl/out_fifo.sv
// Small power-of-two FIFO buffering OUT writes toward the consumer.
// head reads 0 when empty; pop while empty is ignored.
module out_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: cnt gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/register_loader.sv
// Destination decode and load for A, B, OUT and PC; owns PC increment.
// OUT_FIFO_EN: buffer OUT writes in out_fifo, else a single pulsed register.
module register_loader
  import minicpu_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             ld_en,
  input  logic [1:0]       ld_sel,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             stall
);

  logic we_a;
  logic we_b;
  logic we_out;
  logic we_pc;

  always_comb begin
    we_a   = 1'b0;
    we_b   = 1'b0;
    we_out = 1'b0;
    we_pc  = 1'b0;
    if (ld_en) begin
      case (ld_sel_e'(ld_sel))
        LD_A:    we_a   = 1'b1;
        LD_B:    we_b   = 1'b1;
        LD_OUT:  we_out = 1'b1;
        LD_PC:   we_pc  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      reg_a <= '0;
      reg_b <= '0;
      pc    <= '0;
    end else begin
      if (we_a) reg_a <= ld_data;
      if (we_b) reg_b <= ld_data;
      if (we_pc)
        pc <= ld_data;
      else if (pc_inc && !stall)
        pc <= pc + WIDTH'(1);
    end
  end

`ifdef OUT_FIFO_EN
  logic full;
  logic empty;
  logic push;
  logic pop;

  // A same-cycle pop frees the slot, so a full FIFO only stalls without ready.
  assign stall     = we_out && full && !out_ready;
  assign push      = we_out && !stall;
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;

  out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push),
    .pop     (pop),
    .din     (ld_data),
    .full    (full),
    .empty   (empty),
    .head    (out_data)
  );
`else
  localparam int unused_depth = OUT_DEPTH;
  logic unused_ready;

  assign unused_ready = out_ready;
  assign stall        = 1'b0;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= we_out;
      if (we_out) out_data <= ld_data;
    end
  end
`endif

endmodule

// File: tb/tb_register_loader.sv
// Self-checking bench for register_loader (default and OUT_FIFO_EN builds).
// Table vectors, directed corner sequences and random traffic vs a model.
module tb_register_loader;

  localparam int W     = 4;
  localparam int DEPTH = 2;
`ifdef OUT_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         n_reset;
  logic         ld_en;
  logic [1:0]   ld_sel;
  logic [W-1:0] ld_data;
  logic         pc_inc;
  logic [W-1:0] reg_a;
  logic [W-1:0] reg_b;
  logic [W-1:0] pc;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         stall;

  int checks = 0;
  int errors = 0;

  int m_a, m_b, m_pc, m_out;
  bit m_ov;
  int q[$];

  typedef struct {
    logic       en;
    logic [1:0] sel;
    logic [3:0] d;
    logic       inc;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] epc;
  } vec_t;

  vec_t tbl[9];

  register_loader #(.WIDTH(W), .OUT_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .ld_data   (ld_data),
    .pc_inc    (pc_inc),
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .pc        (pc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_pc = 0; m_out = 0; m_ov = 0;
    q.delete();
  endfunction

  function automatic bit model_stall();
    return FIFO && ld_en && ld_sel == 2'd2 && q.size() == DEPTH && !out_ready;
  endfunction

  function automatic void model_step();
    bit st, pop, push;
    int d;
    st = model_stall();
    d  = int'(ld_data);
    if (ld_en && ld_sel == 2'd0) m_a = d;
    if (ld_en && ld_sel == 2'd1) m_b = d;
    if (ld_en && ld_sel == 2'd3) m_pc = d;
    else if (pc_inc && !st) m_pc = (m_pc + 1) % 16;
    if (FIFO) begin
      pop  = q.size() > 0 && out_ready;
      push = ld_en && ld_sel == 2'd2 && !st;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end else begin
      m_ov = ld_en && ld_sel == 2'd2;
      if (m_ov) m_out = d;
    end
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_a"}, reg_a, m_a);
    chk({tag, "_b"}, reg_b, m_b);
    chk({tag, "_pc"}, pc, m_pc);
    if (FIFO) begin
      chk({tag, "_odata"}, out_data, q.size() > 0 ? q[0] : 0);
      chk({tag, "_ovalid"}, out_valid, q.size() > 0);
    end else begin
      chk({tag, "_odata"}, out_data, m_out);
      chk({tag, "_ovalid"}, out_valid, m_ov);
    end
  endtask

  // Inputs are already driven; check stall, clock once, check state.
  task automatic cycle(input string tag);
    #1;
    chk({tag, "_stall"}, stall, model_stall());
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic en, input logic [1:0] sel,
                       input logic [3:0] d, input logic inc,
                       input logic rdy);
    ld_en = en; ld_sel = sel; ld_data = d; pc_inc = inc; out_ready = rdy;
  endtask

  task automatic async_reset(input string tag);
    #3;
    n_reset = 1'b0;
    #1;
    model_reset();
    chk({tag, "_rst_a"}, reg_a, 0);
    chk({tag, "_rst_b"}, reg_b, 0);
    chk({tag, "_rst_pc"}, pc, 0);
    chk({tag, "_rst_odata"}, out_data, 0);
    chk({tag, "_rst_ovalid"}, out_valid, 0);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'd0, 4'h5, 1'b0, 4'h5, 4'h0, 4'h0};
    tbl[1] = '{1'b1, 2'd1, 4'hA, 1'b0, 4'h5, 4'hA, 4'h0};
    tbl[2] = '{1'b1, 2'd3, 4'hE, 1'b0, 4'h5, 4'hA, 4'hE};
    tbl[3] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'h5, 4'hA, 4'hF};
    tbl[4] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'h5, 4'hA, 4'h0};
    tbl[5] = '{1'b1, 2'd3, 4'h3, 1'b1, 4'h5, 4'hA, 4'h3};
    tbl[6] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'hF, 4'hA, 4'h4};
    tbl[7] = '{1'b0, 2'd0, 4'h7, 1'b0, 4'hF, 4'hA, 4'h4};
    tbl[8] = '{1'b1, 2'd1, 4'h0, 1'b1, 4'hF, 4'h0, 4'h5};

    n_reset = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
    model_reset();
    #12;
    chk("init_a", reg_a, 0);
    chk("init_pc", pc, 0);
    chk("init_ovalid", out_valid, 0);
    chk("init_odata", out_data, 0);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].en, tbl[i].sel, tbl[i].d, tbl[i].inc, 1'b1);
      cycle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_ea", i), reg_a, tbl[i].ea);
      chk($sformatf("tbl%0d_eb", i), reg_b, tbl[i].eb);
      chk($sformatf("tbl%0d_epc", i), pc, tbl[i].epc);
    end

    if (FIFO) begin
      drive(1'b1, 2'd2, 4'h1, 1'b0, 1'b0);
      cycle("full1");
      drive(1'b1, 2'd2, 4'h2, 1'b0, 1'b0);
      cycle("full2");
      drive(1'b1, 2'd2, 4'h3, 1'b1, 1'b0);
      #1;
      chk("full_stall", stall, 1);
      cycle("full3");
      chk("full_pc_frozen", pc, 5);
      chk("full_head1", out_data, 1);
      drive(1'b1, 2'd2, 4'h3, 1'b1, 1'b1);
      #1;
      chk("pp_nostall", stall, 0);
      cycle("pushpop");
      chk("pp_head2", out_data, 2);
      chk("pp_pc_inc", pc, 6);
      drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
      cycle("drain1");
      chk("drain_head3", out_data, 3);
      cycle("drain2");
      chk("drain_empty", out_valid, 0);
      drive(1'b1, 2'd2, 4'h7, 1'b0, 1'b0);
      cycle("pre_rst1");
      drive(1'b1, 2'd2, 4'h8, 1'b0, 1'b0);
      cycle("pre_rst2");
      chk("pre_rst_valid", out_valid, 1);
    end else begin
      drive(1'b1, 2'd2, 4'h9, 1'b0, 1'b0);
      cycle("out9");
      chk("out9_data", out_data, 9);
      chk("out9_valid", out_valid, 1);
      drive(1'b0, 2'd2, 4'h4, 1'b0, 1'b0);
      cycle("out_idle");
      chk("out_pulse_end", out_valid, 0);
      chk("out_hold", out_data, 9);
      drive(1'b1, 2'd2, 4'h6, 1'b0, 1'b1);
      cycle("pre_rst");
      chk("pre_rst_valid", out_valid, 1);
    end
    drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
    async_reset("mid");
    check_outputs("post_rst");

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) != 0);
      cycle($sformatf("rnd%0d", i));
      if (i == 200) begin
        drive(1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
        async_reset("rnd_rst");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
